// File: rtl/eeprom_pattern_player.sv
// eeprom_pattern_player
// Reads a column pattern from an SPI EEPROM (READ command 0x03) into an
// internal buffer, then plays one column per col_strobe into a chain of
// 74HC595 shift registers.
// Both serial interfaces are SPI mode 0, MSB first.
// A single bit timer is shared between them because only one is active at a time.
module eeprom_pattern_player #(
    parameter int DEPTH       = 20,
    parameter int CHAIN_BYTES = 1,
    parameter int ADDR_W      = 16,
    parameter int START_ADDR  = 0,
    parameter int SCLK_DIV    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     eeprom_miso,
    output logic                     eeprom_cs_n,
    output logic                     eeprom_sclk,
    output logic                     eeprom_mosi,
    input  logic                     col_strobe,
    input  logic                     dir,
    output logic                     hc595_sclk,
    output logic                     hc595_dat,
    output logic                     hc595_latch,
    output logic                     loaded,
    output logic                     busy,
    output logic                     overrun,
    output logic [$clog2(DEPTH)-1:0] col_index
);

    localparam int IDX_W      = $clog2(DEPTH);
    localparam int TOTAL      = DEPTH * CHAIN_BYTES;
    localparam int AW         = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int ADDR_BYTES = ADDR_W / 8;
    localparam int CMD_BYTES  = 1 + ADDR_BYTES;
    localparam int CMD_BITS   = 8 * CMD_BYTES;
    // One byte counter serves the command, the data read and the column
    // bytes, so it is sized for the largest of them.
    localparam int CNT_W      = $clog2(TOTAL + CMD_BYTES + 1);
    localparam int DIV_W      = $clog2(SCLK_DIV + 1);

    localparam logic [ADDR_W-1:0] START_VEC = ADDR_W'(START_ADDR);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_CMD  = 3'd1,
        LOAD_DATA = 3'd2,
        READY     = 3'd3,
        SHIFT     = 3'd4,
        LATCH     = 3'd5
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [DIV_W-1:0]    div_reg;
    logic                half_reg;
    logic [2:0]          bit_reg;
    logic [CNT_W-1:0]    byte_reg;
    logic [CMD_BITS-1:0] cmd_sr_reg;
    logic [6:0]          rx_sr_reg;
    logic [7:0]          tx_sr_reg;
    logic                dir_reg;
    logic                loaded_reg;
    logic                overrun_reg;
    logic [IDX_W-1:0]    col_reg;
    logic [IDX_W-1:0]    col_next;

    // Pattern buffer, byte n of the read lands at address n.
    logic [7:0]          mem [TOTAL];
    logic [7:0]          rd_data_reg;
    logic [AW-1:0]       rd_addr;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [7:0]          wr_data;

    logic [CMD_BITS-1:0] cmd_word;
    logic                active;
    logic                in_load;
    logic                div_last;
    logic                rise;
    logic                bit_end;
    logic                byte_end;
    logic                byte_last;
    logic                phase_end;
    logic                keep_timing;

    // READ command followed by the start address, most significant byte first.
    assign cmd_word[CMD_BITS-1 -: 8] = 8'h03;
    generate
        for (genvar gi = 0; gi < ADDR_BYTES; gi++) begin : g_addr_byte
            assign cmd_word[(ADDR_BYTES-1-gi)*8 +: 8] = START_VEC[(ADDR_BYTES-1-gi)*8 +: 8];
        end
    endgenerate

    // Bit timing: each bit is SCLK_DIV cycles low, then SCLK_DIV cycles high.
    assign in_load  = (state_reg == LOAD_CMD) || (state_reg == LOAD_DATA);
    assign active   = in_load || (state_reg == SHIFT) || (state_reg == LATCH);
    assign div_last = (div_reg == DIV_W'(SCLK_DIV - 1));
    assign rise     = active && !half_reg && div_last;
    assign bit_end  = active && half_reg && div_last;
    assign byte_end = bit_end && (bit_reg == 3'd7);

    // Last byte of the current phase.
    always_comb begin
        byte_last = 1'b0;
        case (state_reg)
            LOAD_CMD:  byte_last = (byte_reg == CNT_W'(CMD_BYTES - 1));
            LOAD_DATA: byte_last = (byte_reg == CNT_W'(TOTAL - 1));
            SHIFT:     byte_last = (byte_reg == CNT_W'(CHAIN_BYTES - 1));
            default:   byte_last = 1'b0;
        endcase
    end

    // LATCH is timed as one "bit": low half is the gap, high half is the pulse.
    assign phase_end = (state_reg == LATCH) ? bit_end : (byte_end && byte_last);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; run=0 aborts a load but lets a column finish.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (run) begin
                    state_next = loaded_reg ? READY : LOAD_CMD;
                end
            end
            LOAD_CMD: begin
                if (!run) begin
                    state_next = IDLE;
                end else if (phase_end) begin
                    state_next = LOAD_DATA;
                end
            end
            LOAD_DATA: begin
                if (!run) begin
                    state_next = IDLE;
                end else if (phase_end) begin
                    state_next = READY;
                end
            end
            READY: begin
                if (!run) begin
                    state_next = IDLE;
                end else if (col_strobe) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (phase_end) begin
                    state_next = LATCH;
                end
            end
            LATCH: begin
                if (phase_end) begin
                    state_next = run ? READY : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Column index after this cycle: cleared on load completion, stepped on LATCH exit.
    always_comb begin
        col_next = col_reg;
        if ((state_reg == LOAD_DATA) && (state_next == READY)) begin
            col_next = '0;
        end else if ((state_reg == LATCH) && phase_end) begin
            if (dir_reg) begin
                col_next = (col_reg == IDX_W'(DEPTH - 1)) ? '0 : col_reg + IDX_W'(1);
            end else begin
                col_next = (col_reg == '0) ? IDX_W'(DEPTH - 1) : col_reg - IDX_W'(1);
            end
        end
    end

    // Read address: in SHIFT prefetch the next byte of the column; elsewhere
    // keep byte 0 of the upcoming column ready so a strobe can use it at once.
    always_comb begin
        if ((state_reg == SHIFT) && !byte_last) begin
            rd_addr = AW'(int'(col_reg) * CHAIN_BYTES + int'(byte_reg) + 1);
        end else begin
            rd_addr = AW'(int'(col_next) * CHAIN_BYTES);
        end
    end

    assign keep_timing = active && (state_next != IDLE) && (state_next != READY);
    assign wr_en       = (state_reg == LOAD_DATA) && rise && (bit_reg == 3'd7);
    assign wr_addr     = AW'(byte_reg);
    assign wr_data     = {rx_sr_reg, eeprom_miso};

    // Bit timer and bit/byte counters; cleared whenever no transfer is running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_reg  <= '0;
            half_reg <= 1'b0;
            bit_reg  <= '0;
            byte_reg <= '0;
        end else if (!keep_timing) begin
            div_reg  <= '0;
            half_reg <= 1'b0;
            bit_reg  <= '0;
            byte_reg <= '0;
        end else begin
            if (div_last) begin
                div_reg  <= '0;
                half_reg <= ~half_reg;
            end else begin
                div_reg <= div_reg + DIV_W'(1);
            end
            if (bit_end && (state_reg != LATCH)) begin
                if (bit_reg == 3'd7) begin
                    bit_reg  <= '0;
                    byte_reg <= byte_last ? '0 : byte_reg + CNT_W'(1);
                end else begin
                    bit_reg <= bit_reg + 3'd1;
                end
            end
        end
    end

    // Shift registers for command out, EEPROM data in and 595 data out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_sr_reg <= '0;
            rx_sr_reg  <= '0;
            tx_sr_reg  <= '0;
            dir_reg    <= 1'b0;
        end else begin
            if ((state_reg == IDLE) && (state_next == LOAD_CMD)) begin
                cmd_sr_reg <= cmd_word;
            end else if ((state_reg == LOAD_CMD) && bit_end) begin
                cmd_sr_reg <= {cmd_sr_reg[CMD_BITS-2:0], 1'b0};
            end
            if ((state_reg == LOAD_DATA) && rise) begin
                rx_sr_reg <= {rx_sr_reg[5:0], eeprom_miso};
            end
            if ((state_reg == READY) && (state_next == SHIFT)) begin
                tx_sr_reg <= rd_data_reg;
                dir_reg   <= dir;
            end else if ((state_reg == SHIFT) && bit_end) begin
                tx_sr_reg <= byte_end ? rd_data_reg : {tx_sr_reg[6:0], 1'b0};
            end
        end
    end

    // Status flags and column index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loaded_reg  <= 1'b0;
            overrun_reg <= 1'b0;
            col_reg     <= '0;
        end else begin
            if ((state_reg == LOAD_DATA) && (state_next == READY)) begin
                loaded_reg <= 1'b1;
            end
            if (col_strobe && ((state_reg == SHIFT) || (state_reg == LATCH))) begin
                overrun_reg <= 1'b1;
            end
            col_reg <= col_next;
        end
    end

    // Buffer with registered read; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_reg <= mem[rd_addr];
    end

    // Outputs decoded from state and timer registers.
    always_comb begin
        eeprom_cs_n = !in_load;
        eeprom_sclk = in_load && half_reg;
        eeprom_mosi = (state_reg == LOAD_CMD) && cmd_sr_reg[CMD_BITS-1];
        hc595_sclk  = (state_reg == SHIFT) && half_reg;
        hc595_dat   = (state_reg == SHIFT) && tx_sr_reg[7];
        hc595_latch = (state_reg == LATCH) && half_reg;
        busy        = active;
        loaded      = loaded_reg;
        overrun     = overrun_reg;
        col_index   = col_reg;
    end

endmodule

// File: tb/tb_eeprom_pattern_player.sv
// Testbench for eeprom_pattern_player: behavioural SPI EEPROM and 595 chain
// models, reference column model, directed steps with randomized directions.
module tb_eeprom_pattern_player;

    localparam int DEPTH = 4;
    localparam int CB    = 2;
    localparam int START = 16'h0100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       eeprom_miso = 1'b0;
    logic       col_strobe = 1'b0;
    logic       dir = 1'b0;
    logic       eeprom_cs_n, eeprom_sclk, eeprom_mosi;
    logic       hc595_sclk, hc595_dat, hc595_latch;
    logic       loaded, busy, overrun;
    logic [1:0] col_index;

    always #5 clk = ~clk;

    eeprom_pattern_player #(
        .DEPTH(DEPTH), .CHAIN_BYTES(CB), .ADDR_W(16), .START_ADDR(START), .SCLK_DIV(2)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .eeprom_miso(eeprom_miso),
        .eeprom_cs_n(eeprom_cs_n), .eeprom_sclk(eeprom_sclk), .eeprom_mosi(eeprom_mosi),
        .col_strobe(col_strobe), .dir(dir),
        .hc595_sclk(hc595_sclk), .hc595_dat(hc595_dat), .hc595_latch(hc595_latch),
        .loaded(loaded), .busy(busy), .overrun(overrun), .col_index(col_index)
    );

    int vectors = 0;
    int miscompares = 0;

    // EEPROM contents starting at address START.
    logic [7:0]  ee_data [8];
    int          ee_bits = 0;
    int          ee_rise_total = 0;
    logic [23:0] ee_cmd = '0;

    // 595 chain observation.
    logic [15:0] sh16 = '0;
    logic [15:0] latched = '0;
    int          sh_rise = 0;
    int          latch_cnt = 0;
    int          latch_cycles = 0;
    int          cyc = 0;
    int          last_fall = 0;
    int          latch_start = 0;
    int          cs_low_cycles = 0;
    logic        prev_sclk595 = 1'b0;
    logic        prev_latch = 1'b0;

    int          model_col = 0;

    function automatic logic [7:0] ee_byte(input int a);
        int i;
        i = a - START;
        if (i >= 0 && i < 8) return ee_data[i];
        return 8'hEE;
    endfunction

    always @(negedge eeprom_cs_n) begin
        ee_bits = 0;
        ee_cmd  = '0;
    end

    always @(posedge eeprom_sclk) begin
        if (!eeprom_cs_n) begin
            if (ee_bits < 24) ee_cmd = {ee_cmd[22:0], eeprom_mosi};
            ee_bits++;
            ee_rise_total++;
        end
    end

    // Mode 0 slave: next data bit appears on the falling edge after the address.
    always @(negedge eeprom_sclk) begin
        if (!eeprom_cs_n && ee_bits >= 24) begin
            int k;
            logic [7:0] b;
            k = ee_bits - 24;
            b = ee_byte(int'(ee_cmd[15:0]) + k / 8);
            eeprom_miso = b[7 - (k % 8)];
        end
    end

    always @(posedge hc595_sclk) begin
        sh16 = {sh16[14:0], hc595_dat};
        sh_rise++;
    end

    always @(posedge hc595_latch) begin
        latched = sh16;
        latch_cnt++;
    end

    always @(negedge clk) begin
        cyc++;
        if (prev_sclk595 && !hc595_sclk) last_fall = cyc;
        if (!prev_latch && hc595_latch) latch_start = cyc;
        if (hc595_latch) latch_cycles++;
        if (!eeprom_cs_n) cs_low_cycles++;
        prev_sclk595 = hc595_sclk;
        prev_latch   = hc595_latch;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_loaded(input string tag);
        for (int i = 0; i < 3000 && !loaded; i++) @(negedge clk);
        check(tag, loaded, 1);
    endtask

    // One column transaction; second_at>0 adds an extra strobe that many cycles later.
    task automatic play(input logic d, input string tag, input int second_at);
        int c;
        logic [15:0] exp;
        c = model_col;
        exp = {ee_data[c*CB], ee_data[c*CB+1]};
        sh_rise = 0;
        latch_cnt = 0;
        latch_cycles = 0;
        col_strobe = 1'b1;
        dir = d;
        @(negedge clk);
        col_strobe = 1'b0;
        dir = 1'($urandom);
        check($sformatf("%s.first_bit", tag), hc595_dat, exp[15]);
        if (second_at > 0) begin
            tick(second_at - 1);
            col_strobe = 1'b1;
            @(negedge clk);
            col_strobe = 1'b0;
        end
        for (int i = 0; i < 500 && busy; i++) @(negedge clk);
        model_col = d ? (c + 1) % DEPTH : (c + DEPTH - 1) % DEPTH;
        check($sformatf("%s.done", tag), busy, 0);
        check($sformatf("%s.rises", tag), sh_rise, 16);
        check($sformatf("%s.latches", tag), latch_cnt, 1);
        check($sformatf("%s.latch_width", tag), latch_cycles, 2);
        check($sformatf("%s.latch_delay", tag), latch_start - last_fall, 2);
        check($sformatf("%s.pattern", tag), latched, exp);
        check($sformatf("%s.col_index", tag), col_index, model_col);
        $display("strobe %s dir=%0d col=%0d pattern=%04h next_col=%0d", tag, d, c, latched, col_index);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) ee_data[i] = 8'(8'h10 + i);

        // Reset state
        tick(3);
        check("rst.cs_n", eeprom_cs_n, 1);
        check("rst.sclk", eeprom_sclk, 0);
        check("rst.mosi", eeprom_mosi, 0);
        check("rst.595", {hc595_sclk, hc595_dat, hc595_latch}, 0);
        check("rst.flags", {loaded, busy, overrun}, 0);
        check("rst.col", col_index, 0);

        // Load
        reset = 1'b0;
        tick(2);
        cs_low_cycles = 0;
        run = 1'b1;
        @(negedge clk);
        check("load.cs_low_next", eeprom_cs_n, 0);
        check("load.busy", busy, 1);
        wait_loaded("load.loaded");
        check("load.cmd", ee_cmd, 24'h030100);
        check("load.sclk_periods", ee_bits, 88);
        check("load.cs_low_cycles", cs_low_cycles, 352);
        check("load.cs_high", eeprom_cs_n, 1);
        check("load.col", col_index, 0);
        check("load.busy_after", busy, 0);
        $display("load cmd=%06h periods=%0d", ee_cmd, ee_bits);

        // Forward play with wrap
        for (int i = 0; i < 4; i++) play(1'b1, $sformatf("fwd%0d", i), 0);
        check("fwd.wrap", col_index, 0);

        // Reverse play
        play(1'b0, "rev0", 0);
        check("rev.wrap", col_index, 3);
        play(1'b0, "rev1", 0);

        // Random directions
        for (int i = 0; i < 8; i++) begin
            tick($urandom_range(0, 5));
            play(1'($urandom), $sformatf("rnd%0d", i), 0);
        end

        // Overrun
        check("ovr.before", overrun, 0);
        play(1'b1, "ovr", 5);
        check("ovr.set", overrun, 1);
        play(1'($urandom), "ovr_hold", 0);
        check("ovr.held", overrun, 1);

        // Replay without EEPROM traffic
        run = 1'b0;
        tick(5);
        check("stop.busy", busy, 0);
        begin
            int rb, cb;
            rb = ee_rise_total;
            cb = cs_low_cycles;
            run = 1'b1;
            tick(30);
            check("replay.no_sclk", ee_rise_total, rb);
            check("replay.no_cs", cs_low_cycles, cb);
            check("replay.loaded", loaded, 1);
        end
        play(1'b1, "replay", 0);

        // Reset in the middle of a column
        col_strobe = 1'b1;
        dir = 1'b1;
        @(negedge clk);
        col_strobe = 1'b0;
        tick(5);
        #2 reset = 1'b1;
        #1;
        check("mid_rst.flags", {loaded, busy, overrun}, 0);
        check("mid_rst.595", {hc595_sclk, hc595_dat, hc595_latch}, 0);
        check("mid_rst.col", col_index, 0);
        check("mid_rst.cs_n", eeprom_cs_n, 1);
        model_col = 0;
        @(negedge clk);
        reset = 1'b0;
        tick(2);

        // Abort part way through a load, with fresh random contents
        for (int i = 0; i < 8; i++) ee_data[i] = 8'($urandom);
        run = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2000 && ee_bits < 20; i++) @(negedge clk);
        check("abort.progress", ee_bits >= 20, 1);
        run = 1'b0;
        @(negedge clk);
        check("abort.cs_n", eeprom_cs_n, 1);
        check("abort.sclk", eeprom_sclk, 0);
        check("abort.loaded", loaded, 0);
        tick(3);
        check("abort.busy", busy, 0);

        // Restart loads from the command byte
        cs_low_cycles = 0;
        run = 1'b1;
        wait_loaded("reload.loaded");
        check("reload.cmd", ee_cmd, 24'h030100);
        check("reload.sclk_periods", ee_bits, 88);
        check("reload.cs_low_cycles", cs_low_cycles, 352);
        check("reload.col", col_index, 0);
        for (int i = 0; i < 6; i++) begin
            tick($urandom_range(0, 3));
            play(1'($urandom), $sformatf("reload%0d", i), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/eeprom_pattern_player.md
Name: eeprom_pattern_player

Overview:
- Loads a column pattern from an SPI EEPROM into an internal buffer on `run`. The buffer holds DEPTH columns of CHAIN_BYTES bytes each.
- Plays the pattern out to a chain of 74HC595 shift registers, one column per `col_strobe` from the stepper controller. Direction is selectable per column.
- Parametrised successor of the fixed 20-byte, single-595 player in the top level. It sits between the stepper controller and the EEPROM/595 pins.

Parameters:
- DEPTH, 20, number of columns stored (at least 2).
- CHAIN_BYTES, 1, number of bytes per column (number of 595s in the chain, at least 1).
- ADDR_W, 16, EEPROM address width in bits: 8, 16 or 24.
- START_ADDR, 0, first EEPROM address read.
- SCLK_DIV, 2, clk cycles per SCLK half-period (at least 1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level; high starts or continues operation, low stops.
- eeprom_miso  in  1  EEPROM serial data out.
- eeprom_cs_n  out  1  EEPROM chip select, active low.
- eeprom_sclk  out  1  EEPROM SPI clock.
- eeprom_mosi  out  1  EEPROM serial data in.
- col_strobe  in  1  single-cycle pulse requesting the next column.
- dir  in  1  1 = advance col_index, 0 = retreat; sampled with col_strobe.
- hc595_sclk  out  1  595 shift clock.
- hc595_dat  out  1  595 serial data.
- hc595_latch  out  1  595 storage-register clock.
- loaded  out  1  buffer holds a complete pattern.
- busy  out  1  high in LOAD_CMD, LOAD_DATA, SHIFT and LATCH.
- overrun  out  1  sticky; a strobe arrived while a column was in flight.
- col_index  out  $clog2(DEPTH)  column sent on the next strobe.

Behaviour:
- Reset values: eeprom_cs_n=1; every other output =0; state IDLE; buffer contents don't-care.
- SPI is mode 0, MSB first, for both interfaces.
  - SCLK idles low; each bit lasts 2*SCLK_DIV clk cycles.
  - Data changes at bit start, SCLK_DIV cycles before the rising edge.
  - eeprom_miso is sampled on the clk edge where eeprom_sclk goes high.
- States: IDLE, LOAD_CMD, LOAD_DATA, READY, SHIFT, LATCH.
- IDLE:
  - run=1 and loaded=0: go to LOAD_CMD and assert eeprom_cs_n=0 the next cycle.
  - run=1 and loaded=1: go to READY.
- LOAD_CMD: send 0x03, then START_ADDR as ADDR_W/8 bytes, MSB byte first.
- LOAD_DATA:
  - Read DEPTH*CHAIN_BYTES bytes; byte n goes to buffer[n] (column n/CHAIN_BYTES, byte n%CHAIN_BYTES).
  - After the last bit: eeprom_cs_n=1 and loaded=1 in the same cycle; col_index=0; go to READY.
  - eeprom_cs_n stays low continuously from the first command bit to the last data bit.
- READY:
  - run=0: go to IDLE.
  - col_strobe: latch dir and go to SHIFT.
- SHIFT:
  - Send the CHAIN_BYTES bytes of column col_index, byte 0 first; the first data bit is on hc595_dat the cycle after the strobe.
  - hc595_dat=0 whenever not in SHIFT.
- LATCH:
  - hc595_latch is high for SCLK_DIV cycles, starting SCLK_DIV cycles after the final falling edge of hc595_sclk.
  - On exit, col_index becomes col_index±1 per the latched dir, wrapping DEPTH-1 to 0 when advancing and 0 to DEPTH-1 when retreating.
  - Next state is READY if run=1, otherwise IDLE.
- col_strobe in SHIFT or LATCH: ignored; overrun is set. overrun clears only on reset.
- run=0 during LOAD_CMD/LOAD_DATA:
  - Abort the next cycle: eeprom_cs_n=1, eeprom_sclk=0, loaded stays 0, go to IDLE.
  - A later run=1 restarts the load from the command byte.
- run=0 during SHIFT/LATCH: the column completes, including the latch, then the block goes to IDLE.
- loaded is cleared only by reset. A stop/run cycle replays the buffer without re-reading the EEPROM.
- Counters size themselves from the parameters; no arithmetic overflow is permitted for any legal parameter set.
- reset mid-transfer forces all reset values immediately, asynchronously.

Test Plan (DEPTH=4, CHAIN_BYTES=2, ADDR_W=16, START_ADDR=0x0100, SCLK_DIV=2, EEPROM model returns 0x10..0x17):
- Load: reset, then run=1 -> mosi bytes 0x03,0x01,0x00; cs_n low for exactly 88 SCLK periods; loaded=1, col_index=0, busy=0 afterwards.
- Forward play, dir=1:
  - Strobe -> hc595_dat shifts 0x10 then 0x11, 16 rising edges, one latch pulse 2 cycles wide, col_index=1.
  - Four strobes total -> col_index wraps to 0.
- Reverse play: from col_index=0, strobe with dir=0 -> shifts 0x10,0x11; col_index=3; next strobe shifts 0x16,0x17.
- Overrun: second strobe 5 cycles after the first -> ignored; exactly 16 SCLK edges; overrun=1 and held until reset.
- Abort: run=0 after 20 SCLK periods of the load -> cs_n=1 next cycle, loaded=0; run=1 -> full load restarts with 0x03.
- Replay and reset: after a load, run 0->1 produces no EEPROM traffic and READY is reached. reset asserted mid-SHIFT -> all outputs at reset values in the same cycle; loaded=0.
